// File: rtl/apb_pkg.sv
// apb_pkg: shared APB FSM encoding, response codes and wait-counter width
package apb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} apb_state_e;
  localparam logic OKAY = 1'b0;
  localparam logic SLVERR = 1'b1;
  localparam int WAIT_W = 4;
endpackage

// File: rtl/apb_wait_ctr.sv
// apb_wait_ctr: loadable down-counter with zero flag that gates Pready
module apb_wait_ctr
  import apb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              dec,
  input  logic [WAIT_W-1:0] val,
  output logic              zero
);
  logic [WAIT_W-1:0] cnt;
  assign zero = cnt == '0;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= val;
    else if (dec && !zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: parametrised APB slave register file with wait states and range error
// Optional byte strobes via APB_PSTRB_EN.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 3,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              Pclk,
  input  logic              Prst,
  input  logic              Psel,
  input  logic              Penable,
  input  logic              Pwrite,
  input  logic [ADDR_W-1:0] Paddr,
  input  logic [DATA_W-1:0] Pwdata,
`ifdef APB_PSTRB_EN
  input  logic [DATA_W/8-1:0] Pstrb,
`endif
  output logic [DATA_W-1:0] Prdata,
  output logic              Pready,
  output logic              Pslverr
);
  apb_state_e state;
  logic [ADDR_W-1:0] addr_q;
  logic write_q, err_q, zero, in_range, done;
  logic [DATA_W/8-1:0] strb;
  logic [DATA_W-1:0] regs [DEPTH];
`ifdef APB_PSTRB_EN
  assign strb = Pstrb;
`else
  assign strb = '1;
`endif
  assign in_range = {1'b0, Paddr} < (ADDR_W+1)'(DEPTH);
  assign Pready = !Prst && state == ACCESS && zero;
  assign Pslverr = (Pready && err_q) ? SLVERR : OKAY;
  assign done = Psel && Penable && Pready;
  apb_wait_ctr u_ctr (
    .clk  (Pclk),
    .rst  (Prst),
    .load (state == SETUP),
    .dec  (state == ACCESS),
    .val  (WAIT_W'(WAIT_CYCLES)),
    .zero (zero)
  );
  always_ff @(posedge Pclk)
    if (Prst) begin
      state <= IDLE;
      addr_q <= '0;
      write_q <= 1'b0;
      err_q <= 1'b0;
      Prdata <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: if (Psel && !Penable) state <= SETUP;
        SETUP: begin
          state <= ACCESS;
          addr_q <= Paddr;
          write_q <= Pwrite;
          err_q <= !in_range;
          if (!Pwrite) Prdata <= in_range ? regs[Paddr] : '0;
        end
        ACCESS: begin
          if (!Psel) state <= IDLE;
          else if (zero) state <= !Penable ? SETUP : IDLE;
          // Pwdata is taken on the completing edge; address was latched at SETUP
          if (done && write_q && !err_q)
            for (int b = 0; b < DATA_W/8; b++)
              if (strb[b]) regs[addr_q][8*b +: 8] <= Pwdata[8*b +: 8];
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: scoreboard bench for two apb_slave_regfile configurations
module tb_apb_slave_regfile;
  logic Pclk = 0, Prst = 1, Penable = 0, Pwrite = 0;
  logic [1:0] sel = 2'b00;
  logic [2:0] Paddr = 0;
  logic [15:0] Pwdata = 0;
  logic [1:0] Pstrb = 2'b11;
  logic [15:0] rd0, rd1;
  logic rdy0, rdy1, err0, err1;
  int tgt = 0, checks = 0, errors = 0, acc = 0;
  typedef struct {int t; logic [15:0] rd; logic err; int cyc;} exp_t;
  exp_t q[$];
  exp_t e;

  always #5 Pclk = ~Pclk;

  apb_slave_regfile u0 (
    .Pclk(Pclk), .Prst(Prst), .Psel(sel[0]), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata),
`ifdef APB_PSTRB_EN
    .Pstrb(Pstrb),
`endif
    .Prdata(rd0), .Pready(rdy0), .Pslverr(err0)
  );

  apb_slave_regfile #(.DEPTH(6), .WAIT_CYCLES(2)) u1 (
    .Pclk(Pclk), .Prst(Prst), .Psel(sel[1]), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata),
`ifdef APB_PSTRB_EN
    .Pstrb(Pstrb),
`endif
    .Prdata(rd1), .Pready(rdy1), .Pslverr(err1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge Pclk) begin
    if (Prst) acc = 0;
    else if (sel[tgt] && Penable) begin
      acc++;
      if (tgt ? rdy1 : rdy0) begin
        if (q.size() == 0) check("unexpected_ready", 1, 0);
        else begin
          e = q.pop_front();
          check($sformatf("rdata_u%0d", e.t), tgt ? rd1 : rd0, e.rd);
          check($sformatf("slverr_u%0d", e.t), tgt ? err1 : err0, e.err);
          check($sformatf("cycles_u%0d", e.t), acc, e.cyc);
        end
        acc = 0;
      end
    end
  end

  task automatic xfer(input int t, input logic wr, input logic [2:0] a, input logic [15:0] d,
                      input logic [1:0] s, input logic [15:0] rd, input logic err, input logic keep);
    bit ok = 0;
    tgt = t;
    sel = t ? 2'b10 : 2'b01;
    Penable = 0; Pwrite = wr; Paddr = a; Pwdata = d; Pstrb = s;
    q.push_back('{t, rd, err, t ? 4 : 2});
    @(posedge Pclk); #1 Penable = 1;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge Pclk);
      ok = t ? rdy1 : rdy0;
    end
    if (!ok) check("ready_timeout", 0, 1);
    @(posedge Pclk); #1 Penable = 0; Pwdata = 16'hDEAD;
    if (!keep) begin
      sel = 2'b00;
      @(posedge Pclk); #1;
    end
  endtask

  initial begin
    #200000 $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge Pclk);
    @(negedge Pclk);
    check("rst_ready_u0", rdy0, 0); check("rst_err_u0", err0, 0); check("rst_rdata_u0", rd0, 0);
    check("rst_ready_u1", rdy1, 0); check("rst_err_u1", err1, 0); check("rst_rdata_u1", rd1, 0);
    @(posedge Pclk); #1 Prst = 0;
    xfer(0, 1, 2, 16'h0009, 2'b11, 16'h0000, 0, 0);
    xfer(0, 0, 2, 16'h0000, 2'b11, 16'h0009, 0, 0);
    xfer(0, 1, 5, 16'h0001, 2'b11, 16'h0009, 0, 1);
    xfer(0, 0, 5, 16'h0000, 2'b11, 16'h0001, 0, 0);
    xfer(0, 0, 0, 16'h0000, 2'b11, 16'h0000, 0, 0);
    xfer(1, 1, 1, 16'h07FF, 2'b11, 16'h0000, 0, 0);
    xfer(1, 0, 1, 16'h0000, 2'b11, 16'h07FF, 0, 0);
    xfer(1, 1, 7, 16'h0007, 2'b11, 16'h07FF, 1, 0);
    xfer(1, 0, 7, 16'h0000, 2'b11, 16'h0000, 1, 0);
    xfer(1, 1, 6, 16'h5555, 2'b11, 16'h0000, 1, 0);
    xfer(1, 0, 5, 16'h0000, 2'b11, 16'h0000, 0, 0);
    xfer(1, 0, 1, 16'h0000, 2'b11, 16'h07FF, 0, 0);
    tgt = 1; sel = 2'b10; Pwrite = 1; Paddr = 3; Pwdata = 16'hBEEF; Penable = 0;
    @(posedge Pclk); #1 Penable = 1;
    @(posedge Pclk); #1;
    @(posedge Pclk); #1 Prst = 1;
    @(negedge Pclk);
    check("midrst_ready", rdy1, 0);
    @(posedge Pclk); #1 sel = 2'b00; Penable = 0;
    @(negedge Pclk);
    check("postrst_ready", rdy1, 0);
    check("postrst_rdata", rd1, 0);
    @(posedge Pclk); #1 Prst = 0;
    xfer(1, 0, 3, 16'h0000, 2'b11, 16'h0000, 0, 0);
    xfer(0, 0, 2, 16'h0000, 2'b11, 16'h0000, 0, 0);
`ifdef APB_PSTRB_EN
    xfer(0, 1, 4, 16'h1234, 2'b11, 16'h0000, 0, 0);
    xfer(0, 1, 4, 16'hABCD, 2'b01, 16'h0000, 0, 0);
    xfer(0, 0, 4, 16'h0000, 2'b11, 16'h12CD, 0, 0);
    xfer(0, 1, 4, 16'hFFFF, 2'b00, 16'h12CD, 0, 0);
    xfer(0, 0, 4, 16'h0000, 2'b11, 16'h12CD, 0, 0);
`else
    xfer(0, 1, 4, 16'h1234, 2'b11, 16'h0000, 0, 0);
    xfer(0, 1, 4, 16'hABCD, 2'b01, 16'h0000, 0, 0);
    xfer(0, 0, 4, 16'h0000, 2'b11, 16'hABCD, 0, 0);
`endif
    repeat (3) @(posedge Pclk);
    check("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
